// File: rtl/mux4_scan_ctrl.sv
// mux4_scan_ctrl: scan sequencer for an external 4:1 select mux.
// It steps the select code through the enabled channels and waits DWELL cycles
// on each one so the mux output can settle. It then samples F and builds a
// 4-bit frame. It can scan once or rescan continuously.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        begin a scan (accepted only when idle, and only with stop low)
//   stop         abort an active scan; returns to idle at the next edge
//   cont         1 = rescan after each frame, 0 = single frame
//   ch_en[3:0]   channel enable mask, latched when start is accepted
//   f_in         mux output F for the currently selected channel
//   sel[1:0]     select code driven to the mux
//   frame[3:0]   last completed frame; bit i is the sample of channel i
//   frame_valid  one-cycle pulse when frame updates
//   busy         high whenever the sequencer is not idle
module mux4_scan_ctrl #(
  parameter int unsigned DWELL = 2  // settle cycles per channel, 1..255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       cont,
  input  logic [3:0] ch_en,
  input  logic       f_in,
  output logic [1:0] sel,
  output logic [3:0] frame,
  output logic       frame_valid,
  output logic       busy
);

  typedef enum logic [1:0] {StIdle, StSettle, StCapture} state_t;

  localparam logic [7:0] DwellLast = 8'(DWELL - 1);

  state_t     state;
  logic [7:0] cnt;
  logic [3:0] shadow;
  logic [3:0] mask;

  logic [1:0] next_ch;
  logic       has_next;
  logic [3:0] merged;

  function automatic logic [1:0] lowest_ch(input logic [3:0] m);
    logic [1:0] ch;
    ch = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) ch = 2'(i);
    end
    return ch;
  endfunction

  // Lowest enabled channel above the current select, if there is one.
  always_comb begin
    has_next = 1'b0;
    next_ch  = sel;
    for (int i = 3; i >= 0; i--) begin
      if ((i > int'(sel)) && mask[i]) begin
        has_next = 1'b1;
        next_ch  = 2'(i);
      end
    end
  end

  // Shadow with the current capture merged in. This is the frame value on the last channel.
  always_comb begin
    merged      = shadow;
    merged[sel] = f_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= StIdle;
      sel         <= 2'd0;
      cnt         <= 8'd0;
      shadow      <= 4'd0;
      mask        <= 4'd0;
      frame       <= 4'd0;
      frame_valid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start && !stop) begin
            mask <= ch_en;
            if (ch_en == 4'd0) begin
              // Nothing to scan: report an empty frame at once.
              frame       <= 4'd0;
              frame_valid <= 1'b1;
            end else begin
              sel    <= lowest_ch(ch_en);
              cnt    <= 8'd0;
              shadow <= 4'd0;
              state  <= StSettle;
              busy   <= 1'b1;
            end
          end
        end
        StSettle: begin
          if (stop) begin
            state <= StIdle;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 8'd1;
            if (cnt == DwellLast) state <= StCapture;
          end
        end
        StCapture: begin
          if (stop) begin
            state <= StIdle;
            busy  <= 1'b0;
          end else begin
            shadow[sel] <= f_in;
            cnt         <= 8'd0;
            if (has_next) begin
              sel   <= next_ch;
              state <= StSettle;
            end else begin
              frame       <= merged;
              frame_valid <= 1'b1;
              if (cont) begin
                sel    <= lowest_ch(mask);
                shadow <= 4'd0;
                state  <= StSettle;
              end else begin
                state <= StIdle;
                busy  <= 1'b0;
              end
            end
          end
        end
        default: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux4_scan_ctrl.sv
module tb_mux4_scan_ctrl;

  localparam int unsigned Dwell = 2;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic       cont;
  logic [3:0] ch_en;
  logic       f_in;
  logic [1:0] sel;
  logic [3:0] frame;
  logic       frame_valid;
  logic       busy;

  logic [3:0] i_vec;  // static mux inputs I[3:0]
  logic [3:0] last_frame;

  int checks;
  int errors;

  mux4_scan_ctrl #(.DWELL(Dwell)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .cont        (cont),
    .ch_en       (ch_en),
    .f_in        (f_in),
    .sel         (sel),
    .frame       (frame),
    .frame_valid (frame_valid),
    .busy        (busy)
  );

  // Behavioural 4:1 mux
  assign f_in = i_vec[sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected select trace: each enabled channel in ascending order, held Dwell+1 cycles.
  task automatic build_seq(input logic [3:0] m, output int seq[$]);
    seq = {};
    for (int ch = 0; ch < 4; ch++) begin
      if (m[ch]) begin
        for (int k = 0; k < int'(Dwell) + 1; k++) seq.push_back(ch);
      end
    end
  endtask

  // Single-shot scan with random start/ch_en noise while the scan is busy.
  task automatic run_scan(input logic [3:0] m, input logic [3:0] iv);
    int seq[$];
    int n;
    build_seq(m, seq);
    n     = seq.size();
    ch_en = m;
    i_vec = iv;
    cont  = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    if (m == 4'd0) begin
      check("empty_fv", 32'(frame_valid), 32'd1);
      check("empty_frame", 32'(frame), 32'd0);
      check("empty_busy", 32'(busy), 32'd0);
      last_frame = 4'd0;
    end else begin
      for (int k = 0; k < n; k++) begin
        check("scan_sel", 32'(sel), 32'(seq[k]));
        check("scan_busy", 32'(busy), 32'd1);
        check("scan_fv_low", 32'(frame_valid), 32'd0);
        if (k < n - 1) begin
          start = 1'($urandom_range(0, 1));
          ch_en = 4'($urandom);
        end else begin
          start = 1'b0;
        end
        step();
      end
      check("done_fv", 32'(frame_valid), 32'd1);
      check("done_frame", 32'(frame), 32'(iv & m));
      check("done_busy", 32'(busy), 32'd0);
      last_frame = iv & m;
    end
    step();
    check("fv_pulse_end", 32'(frame_valid), 32'd0);
    check("frame_hold", 32'(frame), 32'(last_frame));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    stop   = 1'b0;
    cont   = 1'b0;
    ch_en  = 4'd0;
    i_vec  = 4'd0;
    last_frame = 4'd0;

    #10;
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_frame", 32'(frame), 32'd0);
    check("rst_fv", 32'(frame_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    #2 rst_n = 1'b1;
    step();

    // Directed scans
    run_scan(4'hF, 4'b1010);
    run_scan(4'b0101, 4'b1111);
    run_scan(4'h0, 4'hF);

    // start together with stop in idle is not accepted
    ch_en = 4'hF;
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    check("start_stop_busy", 32'(busy), 32'd0);
    check("start_stop_fv", 32'(frame_valid), 32'd0);

    // Randomised single-shot scans
    for (int t = 0; t < 24; t++) begin
      run_scan(4'($urandom), 4'($urandom));
    end

    // Continuous mode: two frames with the inputs changed in between; cont dropped mid-frame 2
    run_scan(4'hF, 4'hA);
    ch_en = 4'hF;
    i_vec = 4'h3;
    cont  = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 4 * (int'(Dwell) + 1); k++) begin
      check("cont1_busy", 32'(busy), 32'd1);
      step();
    end
    check("cont1_fv", 32'(frame_valid), 32'd1);
    check("cont1_frame", 32'(frame), 32'h3);
    check("cont1_busy_after", 32'(busy), 32'd1);
    check("cont1_sel_wrap", 32'(sel), 32'd0);
    i_vec = 4'hC;
    for (int k = 0; k < 4 * (int'(Dwell) + 1); k++) begin
      if (k == 5) cont = 1'b0;
      check("cont2_busy", 32'(busy), 32'd1);
      check("cont2_frame_hold", 32'(frame), 32'h3);
      if (k > 0) check("cont2_fv_low", 32'(frame_valid), 32'd0);
      step();
    end
    check("cont2_fv", 32'(frame_valid), 32'd1);
    check("cont2_frame", 32'(frame), 32'hC);
    check("cont2_busy_end", 32'(busy), 32'd0);
    last_frame = 4'hC;
    step();

    // Stop during channel 2 settle
    ch_en = 4'hF;
    i_vec = 4'h5;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 2 * (int'(Dwell) + 1); k++) step();
    check("stop_pre_sel", 32'(sel), 32'd2);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("stop_busy", 32'(busy), 32'd0);
    check("stop_fv", 32'(frame_valid), 32'd0);
    check("stop_frame", 32'(frame), 32'(last_frame));
    check("stop_sel_held", 32'(sel), 32'd2);
    for (int k = 0; k < 12; k++) begin
      check("stop_no_fv", 32'(frame_valid), 32'd0);
      step();
    end

    // Async reset mid-scan
    run_scan(4'hF, 4'hA);
    ch_en = 4'hF;
    i_vec = 4'h6;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) step();
    #3 rst_n = 1'b0;
    #1;
    check("arst_sel", 32'(sel), 32'd0);
    check("arst_frame", 32'(frame), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_fv", 32'(frame_valid), 32'd0);
    #2 rst_n = 1'b1;
    step();
    check("arst_idle", 32'(busy), 32'd0);
    run_scan(4'hF, 4'h6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
